// File: rtl/cpu_types.sv
`default_nettype none
// ============================================================================
// Package     : cpu_types
// Description : Shared CPU types. Holds the reservation-station tag space,
//               the packed reservation-station entry and the CDB tag matcher.
// Revision    : 1.0 - reservation-station entry type and tag_match added
// ============================================================================
package cpu_types;

  // Reservation-station tags. INVALID marks "value already present".
  typedef enum logic [2:0] {
    INVALID = 3'd0,
    ALU_1   = 3'd1,
    ALU_2   = 3'd2,
    LOAD_1  = 3'd3,
    LOAD_2  = 3'd4,
    STORE_1 = 3'd5,
    STORE_2 = 3'd6,
    ALU_3   = 3'd7
  } RS_tag_type;

  localparam int RS_DATA_W = 32;
  localparam int RS_OP_W   = 4;

  // One Tomasulo entry as stored in a reservation station.
  typedef struct packed {
    logic                 busy;
    logic                 issued;
    logic [RS_OP_W-1:0]   op;
    RS_tag_type           qj;
    logic [RS_DATA_W-1:0] vj;
    RS_tag_type           qk;
    logic [RS_DATA_W-1:0] vk;
  } rs_entry_t;

  // A pending operand picks up the CDB value only on a valid broadcast of
  // its producer; INVALID never matches, even against an INVALID broadcast.
  function automatic logic tag_match(input RS_tag_type q,
                                     input logic       cdb_valid,
                                     input RS_tag_type cdb_tag);
    return cdb_valid && (q != INVALID) && (q == cdb_tag);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_entry.sv
`default_nettype none
// ============================================================================
// Module      : rs_entry
// Description : One reservation-station entry: dispatch write with CDB
//               bypass, operand capture, ready generation and free on its
//               own tag.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_entry
  import cpu_types::*;
#(
  parameter int         DATA_W = RS_DATA_W,
  parameter int         OP_W   = RS_OP_W,
  parameter RS_tag_type TAG    = ALU_1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              disp_valid_i,
  input  RS_tag_type        disp_tag_i,
  input  logic [OP_W-1:0]   disp_op_i,
  input  RS_tag_type        disp_qj_i,
  input  logic [DATA_W-1:0] disp_vj_i,
  input  RS_tag_type        disp_qk_i,
  input  logic [DATA_W-1:0] disp_vk_i,
  input  logic              cdb_valid_i,
  input  RS_tag_type        cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_value_i,
  input  logic              issue_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic              wr_o,
  output logic              free_o,
  output logic [OP_W-1:0]   op_o,
  output logic [DATA_W-1:0] vj_o,
  output logic [DATA_W-1:0] vk_o
);

  rs_entry_t st_q;
  rs_entry_t st_d;

  logic wr_w;
  logic free_w;

  // The dispatcher sees registered busy, so a same-cycle free does not open the entry.
  assign wr_w   = disp_valid_i && (disp_tag_i == TAG) && !st_q.busy;
  // Only an issued entry can be retired by its own tag on the CDB.
  assign free_w = cdb_valid_i && (cdb_tag_i == TAG) && st_q.issued;

  // Next-state: write wins, then free, otherwise issue marking and operand capture.
  always_comb begin
    st_d = st_q;
    if (wr_w) begin
      st_d.busy   = 1'b1;
      st_d.issued = 1'b0;
      st_d.op     = disp_op_i;
      if (tag_match(disp_qj_i, cdb_valid_i, cdb_tag_i)) begin
        st_d.qj = INVALID;
        st_d.vj = cdb_value_i;
      end else begin
        st_d.qj = disp_qj_i;
        st_d.vj = disp_vj_i;
      end
      if (tag_match(disp_qk_i, cdb_valid_i, cdb_tag_i)) begin
        st_d.qk = INVALID;
        st_d.vk = cdb_value_i;
      end else begin
        st_d.qk = disp_qk_i;
        st_d.vk = disp_vk_i;
      end
    end else if (free_w) begin
      st_d.busy   = 1'b0;
      st_d.issued = 1'b0;
    end else if (st_q.busy) begin
      if (issue_i) begin
        st_d.issued = 1'b1;
      end
      if (tag_match(st_q.qj, cdb_valid_i, cdb_tag_i)) begin
        st_d.qj = INVALID;
        st_d.vj = cdb_value_i;
      end
      if (tag_match(st_q.qk, cdb_valid_i, cdb_tag_i)) begin
        st_d.qk = INVALID;
        st_d.vk = cdb_value_i;
      end
    end
  end

  // Entry register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st_q <= '{busy: 1'b0, issued: 1'b0, op: '0, qj: INVALID, vj: '0,
                qk: INVALID, vk: '0};
    end else begin
      st_q <= st_d;
    end
  end

  // Flag protocol misuse from the dispatcher or the CDB; state is left as is.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      assert (!(disp_valid_i && (disp_tag_i == TAG) && st_q.busy))
        else $warning("rs_entry: dispatch to occupied entry ignored");
      assert (!(cdb_valid_i && (cdb_tag_i == TAG) && st_q.busy && !st_q.issued))
        else $warning("rs_entry: own tag broadcast before issue");
    end
  end

  assign busy_o  = st_q.busy;
  assign ready_o = st_q.busy && !st_q.issued && (st_q.qj == INVALID) &&
                   (st_q.qk == INVALID);
  assign wr_o    = wr_w;
  assign free_o  = free_w;
  assign op_o    = st_q.op;
  assign vj_o    = st_q.vj;
  assign vk_o    = st_q.vk;

endmodule
`default_nettype wire

// File: rtl/rs_pair.sv
`default_nettype none
// ============================================================================
// Module      : rs_pair
// Description : Two-entry reservation-station bank. Adds the age pointer,
//               oldest-ready selection and the FU valid/ready handshake on
//               top of two rs_entry instances.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_pair
  import cpu_types::*;
#(
  parameter int         DATA_W = RS_DATA_W,
  parameter int         OP_W   = RS_OP_W,
  parameter RS_tag_type TAG_0  = ALU_1,
  parameter RS_tag_type TAG_1  = ALU_2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              DISP_VALID,
  input  RS_tag_type        DISP_TAG,
  input  logic [OP_W-1:0]   DISP_OP,
  input  RS_tag_type        DISP_QJ,
  input  logic [DATA_W-1:0] DISP_VJ,
  input  RS_tag_type        DISP_QK,
  input  logic [DATA_W-1:0] DISP_VK,
  input  logic              CDB_VALID,
  input  RS_tag_type        CDB_TAG,
  input  logic [DATA_W-1:0] CDB_VALUE,
  output logic [1:0]        BUSY,
  output logic              FU_VALID,
  input  logic              FU_READY,
  output logic [OP_W-1:0]   FU_OP,
  output logic [DATA_W-1:0] FU_VJ,
  output logic [DATA_W-1:0] FU_VK,
  output RS_tag_type        FU_TAG
);

  logic [1:0]        busy_w;
  logic [1:0]        ready_w;
  logic [1:0]        wr_w;
  logic [1:0]        free_w;
  logic [1:0]        issue_w;
  logic [OP_W-1:0]   op_w [2];
  logic [DATA_W-1:0] vj_w [2];
  logic [DATA_W-1:0] vk_w [2];

  logic older_q;
  logic older_d;
  logic sel_w;
  logic valid_w;
  logic fire_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    rs_entry #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W),
      .TAG    ((gi == 0) ? TAG_0 : TAG_1)
    ) u_entry (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .disp_valid_i (DISP_VALID),
      .disp_tag_i   (DISP_TAG),
      .disp_op_i    (DISP_OP),
      .disp_qj_i    (DISP_QJ),
      .disp_vj_i    (DISP_VJ),
      .disp_qk_i    (DISP_QK),
      .disp_vk_i    (DISP_VK),
      .cdb_valid_i  (CDB_VALID),
      .cdb_tag_i    (CDB_TAG),
      .cdb_value_i  (CDB_VALUE),
      .issue_i      (issue_w[gi]),
      .busy_o       (busy_w[gi]),
      .ready_o      (ready_w[gi]),
      .wr_o         (wr_w[gi]),
      .free_o       (free_w[gi]),
      .op_o         (op_w[gi]),
      .vj_o         (vj_w[gi]),
      .vk_o         (vk_w[gi])
    );
  end

  // Oldest ready entry wins; with a single ready entry it is taken directly.
  // A waiting offer cannot be displaced because a newer entry is never older.
  assign sel_w   = (ready_w[0] && ready_w[1]) ? older_q : ready_w[1];
  assign valid_w = |ready_w;
  assign fire_w  = valid_w && FU_READY;
  assign issue_w = {fire_w && sel_w, fire_w && !sel_w};

  // Age pointer: a new entry is younger than a surviving neighbour.
  always_comb begin
    older_d = older_q;
    if (wr_w[0]) begin
      older_d = (busy_w[1] && !free_w[1]) ? 1'b1 : 1'b0;
    end else if (wr_w[1]) begin
      older_d = (busy_w[0] && !free_w[0]) ? 1'b0 : 1'b1;
    end
  end

  // Age pointer register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      older_q <= 1'b0;
    end else begin
      older_q <= older_d;
    end
  end

  // FU payload comes straight from the selected entry's registers, zeroed when idle.
  always_comb begin
    FU_VALID = valid_w;
    FU_OP    = '0;
    FU_VJ    = '0;
    FU_VK    = '0;
    FU_TAG   = INVALID;
    if (valid_w) begin
      FU_OP  = op_w[sel_w];
      FU_VJ  = vj_w[sel_w];
      FU_VK  = vk_w[sel_w];
      FU_TAG = sel_w ? TAG_1 : TAG_0;
    end
  end

  assign BUSY = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_rs_pair.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_pair
// Description : Directed self-checking bench for the rs_pair bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_pair;
  import cpu_types::*;

  logic        CLK;
  logic        RST_N;
  logic        DISP_VALID;
  RS_tag_type  DISP_TAG;
  logic [3:0]  DISP_OP;
  RS_tag_type  DISP_QJ;
  logic [31:0] DISP_VJ;
  RS_tag_type  DISP_QK;
  logic [31:0] DISP_VK;
  logic        CDB_VALID;
  RS_tag_type  CDB_TAG;
  logic [31:0] CDB_VALUE;
  logic [1:0]  BUSY;
  logic        FU_VALID;
  logic        FU_READY;
  logic [3:0]  FU_OP;
  logic [31:0] FU_VJ;
  logic [31:0] FU_VK;
  RS_tag_type  FU_TAG;

  int tests;
  int fails;

  rs_pair #(.DATA_W(32), .OP_W(4), .TAG_0(ALU_1), .TAG_1(ALU_2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .DISP_VALID(DISP_VALID), .DISP_TAG(DISP_TAG), .DISP_OP(DISP_OP),
    .DISP_QJ(DISP_QJ), .DISP_VJ(DISP_VJ), .DISP_QK(DISP_QK), .DISP_VK(DISP_VK),
    .CDB_VALID(CDB_VALID), .CDB_TAG(CDB_TAG), .CDB_VALUE(CDB_VALUE),
    .BUSY(BUSY), .FU_VALID(FU_VALID), .FU_READY(FU_READY), .FU_OP(FU_OP),
    .FU_VJ(FU_VJ), .FU_VK(FU_VK), .FU_TAG(FU_TAG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    DISP_VALID = 1'b0; DISP_TAG = INVALID; DISP_OP = '0;
    DISP_QJ = INVALID; DISP_VJ = '0; DISP_QK = INVALID; DISP_VK = '0;
    CDB_VALID = 1'b0; CDB_TAG = INVALID; CDB_VALUE = '0;
    FU_READY = 1'b0;
  endtask

  task automatic dispatch(input RS_tag_type t, input logic [3:0] op,
                          input RS_tag_type qj, input logic [31:0] vj,
                          input RS_tag_type qk, input logic [31:0] vk);
    DISP_VALID = 1'b1; DISP_TAG = t; DISP_OP = op;
    DISP_QJ = qj; DISP_VJ = vj; DISP_QK = qk; DISP_VK = vk;
  endtask

  task automatic broadcast(input RS_tag_type t, input logic [31:0] v);
    CDB_VALID = 1'b1; CDB_TAG = t; CDB_VALUE = v;
  endtask

  // Accept the current offer, then retire it with its own tag.
  task automatic drain(input RS_tag_type t);
    FU_READY = 1'b1;
    tick();
    FU_READY = 1'b0;
    broadcast(t, 32'h0);
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 1'b0;
    tick(); tick();
    tests++; if (BUSY !== 2'b00) begin fails++; $display("FAIL reset_busy: got %b want 00", BUSY); end
    tests++; if (FU_VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", FU_VALID); end
    tests++; if (FU_TAG !== INVALID || FU_OP !== 4'd0 || FU_VJ !== 32'd0 || FU_VK !== 32'd0) begin
      fails++; $display("FAIL reset_payload: got tag=%0d op=%0h vj=%0h vk=%0h want 0s", FU_TAG, FU_OP, FU_VJ, FU_VK); end
    RST_N = 1'b1;
  endtask

  task automatic test_dispatch_ready();
    dispatch(ALU_1, 4'd3, INVALID, 32'd5, INVALID, 32'd7);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b01) begin fails++; $display("FAIL disp_busy: got %b want 01", BUSY); end
    tests++; if (FU_VALID !== 1'b1 || FU_OP !== 4'd3 || FU_VJ !== 32'd5 || FU_VK !== 32'd7 || FU_TAG !== ALU_1) begin
      fails++; $display("FAIL disp_offer: got v=%b op=%0h vj=%0h vk=%0h tag=%0d want 1/3/5/7/1", FU_VALID, FU_OP, FU_VJ, FU_VK, FU_TAG); end
    FU_READY = 1'b1;
    tick();
    FU_READY = 1'b0;
    tests++; if (FU_VALID !== 1'b0 || BUSY !== 2'b01) begin
      fails++; $display("FAIL issued_hold: got v=%b busy=%b want 0/01", FU_VALID, BUSY); end
    broadcast(ALU_1, 32'h1234);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b00) begin fails++; $display("FAIL free0: got %b want 00", BUSY); end
  endtask

  task automatic test_cdb_capture();
    dispatch(ALU_2, 4'd5, LOAD_1, 32'd0, INVALID, 32'd9);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b10 || FU_VALID !== 1'b0) begin
      fails++; $display("FAIL capture_wait1: got busy=%b v=%b want 10/0", BUSY, FU_VALID); end
    tick();
    broadcast(LOAD_1, 32'hDEAD);
    tests++; if (FU_VALID !== 1'b0) begin fails++; $display("FAIL capture_wait2: got %b want 0", FU_VALID); end
    tick();
    idle_inputs();
    tests++; if (FU_VALID !== 1'b1 || FU_VJ !== 32'hDEAD || FU_VK !== 32'd9 || FU_TAG !== ALU_2 || FU_OP !== 4'd5) begin
      fails++; $display("FAIL capture_offer: got v=%b vj=%0h vk=%0h tag=%0d op=%0h want 1/dead/9/2/5", FU_VALID, FU_VJ, FU_VK, FU_TAG, FU_OP); end
    drain(ALU_2);
    tests++; if (BUSY !== 2'b00) begin fails++; $display("FAIL free1: got %b want 00", BUSY); end
  endtask

  task automatic test_bypass();
    dispatch(ALU_1, 4'd2, INVALID, 32'd1, ALU_2, 32'd0);
    broadcast(ALU_2, 32'd42);
    tick();
    idle_inputs();
    tests++; if (FU_VALID !== 1'b1 || FU_VK !== 32'd42 || FU_VJ !== 32'd1 || FU_TAG !== ALU_1) begin
      fails++; $display("FAIL bypass_k: got v=%b vk=%0d vj=%0d tag=%0d want 1/42/1/1", FU_VALID, FU_VK, FU_VJ, FU_TAG); end
    drain(ALU_1);
    dispatch(ALU_2, 4'd8, LOAD_2, 32'd3, LOAD_2, 32'd4);
    broadcast(LOAD_2, 32'd77);
    tick();
    idle_inputs();
    tests++; if (FU_VALID !== 1'b1 || FU_VJ !== 32'd77 || FU_VK !== 32'd77 || FU_TAG !== ALU_2) begin
      fails++; $display("FAIL bypass_jk: got v=%b vj=%0d vk=%0d tag=%0d want 1/77/77/2", FU_VALID, FU_VJ, FU_VK, FU_TAG); end
    drain(ALU_2);
  endtask

  task automatic test_age_select();
    dispatch(ALU_2, 4'd1, INVALID, 32'd11, INVALID, 32'd12);
    tick();
    dispatch(ALU_1, 4'd4, INVALID, 32'd21, INVALID, 32'd22);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tests++; if (FU_VALID !== 1'b1 || FU_TAG !== ALU_2 || FU_VJ !== 32'd11 || FU_OP !== 4'd1) begin
        fails++; $display("FAIL age_hold%0d: got v=%b tag=%0d vj=%0d op=%0h want 1/2/11/1", i, FU_VALID, FU_TAG, FU_VJ, FU_OP); end
      tick();
    end
    FU_READY = 1'b1;
    tick();
    FU_READY = 1'b0;
    tests++; if (FU_VALID !== 1'b1 || FU_TAG !== ALU_1 || FU_VJ !== 32'd21 || FU_VK !== 32'd22 || FU_OP !== 4'd4) begin
      fails++; $display("FAIL age_next: got v=%b tag=%0d vj=%0d vk=%0d op=%0h want 1/1/21/22/4", FU_VALID, FU_TAG, FU_VJ, FU_VK, FU_OP); end
  endtask

  task automatic test_free_redispatch();
    FU_READY = 1'b1;
    tick();
    FU_READY = 1'b0;
    tests++; if (FU_VALID !== 1'b0 || BUSY !== 2'b11) begin
      fails++; $display("FAIL both_issued: got v=%b busy=%b want 0/11", FU_VALID, BUSY); end
    broadcast(ALU_1, 32'd0);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b10) begin fails++; $display("FAIL free_e0: got %b want 10", BUSY); end
    dispatch(ALU_1, 4'd6, INVALID, 32'd31, INVALID, 32'd32);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b11 || FU_TAG !== ALU_1 || FU_VJ !== 32'd31) begin
      fails++; $display("FAIL redispatch: got busy=%b tag=%0d vj=%0d want 11/1/31", BUSY, FU_TAG, FU_VJ); end
    dispatch(ALU_2, 4'd9, INVALID, 32'd99, INVALID, 32'd98);
    tick();
    dispatch(STORE_1, 4'd7, INVALID, 32'd55, INVALID, 32'd56);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b11 || FU_TAG !== ALU_1 || FU_VJ !== 32'd31 || FU_OP !== 4'd6) begin
      fails++; $display("FAIL ignored_disp: got busy=%b tag=%0d vj=%0d op=%0h want 11/1/31/6", BUSY, FU_TAG, FU_VJ, FU_OP); end
    broadcast(ALU_2, 32'd0);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b01 || FU_TAG !== ALU_1) begin
      fails++; $display("FAIL free_e1: got busy=%b tag=%0d want 01/1", BUSY, FU_TAG); end
    drain(ALU_1);
  endtask

  task automatic test_mid_reset();
    dispatch(ALU_1, 4'd2, LOAD_1, 32'd0, INVALID, 32'd1);
    tick();
    dispatch(ALU_2, 4'd3, INVALID, 32'd2, STORE_1, 32'd0);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b11 || FU_VALID !== 1'b0) begin
      fails++; $display("FAIL pending_pair: got busy=%b v=%b want 11/0", BUSY, FU_VALID); end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tests++; if (BUSY !== 2'b00 || FU_VALID !== 1'b0 || FU_TAG !== INVALID) begin
      fails++; $display("FAIL mid_reset: got busy=%b v=%b tag=%0d want 00/0/0", BUSY, FU_VALID, FU_TAG); end
    broadcast(LOAD_1, 32'd5);
    tick();
    broadcast(STORE_1, 32'd6);
    tick();
    idle_inputs();
    tests++; if (BUSY !== 2'b00 || FU_VALID !== 1'b0) begin
      fails++; $display("FAIL post_reset_cdb: got busy=%b v=%b want 00/0", BUSY, FU_VALID); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    RST_N = 1'b0;
    test_reset();
    test_dispatch_ready();
    test_cdb_capture();
    test_bypass();
    test_age_select();
    test_free_redispatch();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rs_pair.md
Name: rs_pair

Overview:
- Reservation-station bank at the receiving end of the dispatch interface.
- Holds two Tomasulo entries for one functional-unit class (ALU, LOAD or STORE) and reports per-entry busy back to the issue/dispatch stage.
- Captures pending operands from the common data bus (CDB) and hands ready instructions to its functional unit with a valid/ready handshake.
- Frees an entry when that entry's own tag is broadcast on the CDB.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 4, opcode/function-select width passed to the FU.
- TAG_0, ALU_1, RS_tag_type tag owned by entry 0.
- TAG_1, ALU_2, RS_tag_type tag owned by entry 1.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  synchronous active-low reset.
- DISP_VALID  in  1  dispatch strobe.
- DISP_TAG  in  RS_tag_type  target entry; only TAG_0/TAG_1 are accepted.
- DISP_OP  in  OP_W  operation.
- DISP_QJ  in  RS_tag_type  producer tag of operand j; INVALID means DISP_VJ is valid.
- DISP_VJ  in  DATA_W  operand j value.
- DISP_QK  in  RS_tag_type  producer tag of operand k; INVALID means DISP_VK is valid.
- DISP_VK  in  DATA_W  operand k value.
- CDB_VALID  in  1  result broadcast valid.
- CDB_TAG  in  RS_tag_type  producing tag.
- CDB_VALUE  in  DATA_W  result.
- BUSY  out  2  bit i set while entry i is occupied.
- FU_VALID  out  1  an instruction is offered to the FU.
- FU_READY  in  1  FU accepts this cycle.
- FU_OP  out  OP_W  offered operation.
- FU_VJ  out  DATA_W  offered operand j.
- FU_VK  out  DATA_W  offered operand k.
- FU_TAG  out  RS_tag_type  tag the FU must put on the CDB with its result.

Behaviour:
- Per-entry state: busy, issued, op, Qj, Vj, Qk, Vk. Bank state: one `older` pointer bit.
- Reset (RST_N=0 at posedge): all busy/issued=0, Q fields=INVALID, V fields=0, older=0. Outputs: BUSY=0, FU_VALID=0, FU_OP/FU_VJ/FU_VK=0, FU_TAG=INVALID. Reset overrides any dispatch, CDB or handshake in the same cycle. Mid-operation reset drops all entries; nothing is issued afterwards.
- Dispatch write: when DISP_VALID && DISP_TAG==TAG_i && !busy_i, entry i is written. BUSY[i]=1 the next cycle.
  - DISP_TAG matching neither tag, or addressing a busy entry, is ignored; the simulation assertion fires on the busy case.
  - If busy_i is being cleared in the same cycle, the dispatch is still ignored, because the dispatcher sees the registered BUSY.
- Dispatch bypass: if CDB_VALID && DISP_QJ==CDB_TAG in the dispatch cycle, store Vj=CDB_VALUE and Qj=INVALID. Same rule for K. Both operands may bypass at once.
- Operand capture: each cycle, for every busy entry with Qj==CDB_TAG && CDB_VALID, set Vj=CDB_VALUE and Qj=INVALID. Same rule for K.
  - INVALID never matches, even if CDB_TAG==INVALID.
- Ready: ready_i = busy_i && !issued_i && Qj_i==INVALID && Qk_i==INVALID, computed from registered state only.
- Selection:
  - If both entries are ready, the older entry wins.
  - If one is ready, that entry is selected.
  - FU_VALID = |ready. FU_* outputs are driven combinationally from the selected entry's registers.
  - When FU_VALID=0: FU_OP/FU_VJ/FU_VK=0, FU_TAG=INVALID.
- Latency:
  - Dispatch with both operands ready at edge N → FU_VALID high in cycle N+1.
  - Last operand captured from CDB at edge N → FU_VALID in N+1.
  - Minimum dispatch→FU acceptance is 1 cycle.
- Handshake:
  - FU_VALID && FU_READY at a posedge sets issued for the selected entry.
  - While FU_READY=0, FU_VALID and the FU_* payload stay stable. No re-selection is allowed unless the other entry is older, and it cannot become older while both are waiting.
- Free: CDB_VALID && CDB_TAG==TAG_i && issued_i clears busy_i and issued_i at that edge. BUSY[i]=0 the next cycle.
  - A CDB carrying TAG_i while entry i has not issued is a protocol error. The assertion fires and the state is unchanged.
- Age: on dispatch into entry i, older = ~i if the other entry is busy and not being freed this edge; otherwise older = i.
- Simultaneous events: in one edge the bank may dispatch into one entry, capture CDB operands in the other, accept an FU handshake and free an entry. All of these apply independently.

Decomposition:
- Add to cpu_types: rs_entry_t (packed struct holding busy, issued, op, qj, vj, qk, vk) and the function tag_match(q, cdb_valid, cdb_tag). RS_tag_type and INVALID are already there.
- One sub-module, rs_entry: a single entry's registers, write, CDB capture, ready and free logic, instantiated twice with TAG_0/TAG_1.
- rs_pair adds the age pointer, the selection mux and the handshake.

Test Plan:
- Reset then dispatch to TAG_0 with op=3, Qj=Qk=INVALID, Vj=5, Vk=7 → BUSY=01 next cycle; FU_VALID=1 with FU_OP=3, FU_VJ=5, FU_VK=7, FU_TAG=TAG_0.
- Dispatch to TAG_1 with Qj=LOAD_1; two cycles later CDB_VALID=1, CDB_TAG=LOAD_1, CDB_VALUE=0xDEAD → FU_VALID the next cycle with FU_VJ=0xDEAD; before that, FU_VALID=0.
- Dispatch with Qk=ALU_2 in the same cycle as a CDB broadcast of ALU_2 carrying 42 → entry is ready the next cycle with FU_VK=42.
- Both entries ready and entry 1 dispatched first, FU_READY=0 for 3 cycles → FU_TAG=TAG_1 held stable; on FU_READY=1, TAG_1 is issued and TAG_0 is offered the next cycle.
- Entry 0 issued, then CDB broadcasts TAG_0 → BUSY[0]=0 next cycle; redispatch to TAG_0 the following cycle is accepted. A dispatch to busy TAG_1 is ignored and the assertion fires.
- Two busy entries with pending operands, RST_N=0 for one edge → BUSY=00, FU_VALID=0, FU_TAG=INVALID; a later CDB broadcast of the old producer tag causes no issue.
